// File: rtl/ps_req_tracker_pkg.sv
// Shared parameters, types and helpers for the ps_req_tracker block.
// Sizes match a ps8 priority selector.
package ps_pkg;

  localparam int NUM_REQ      = 8;
  localparam int CNT_W        = 3;
  localparam int STARVE_LIMIT = 15;
  localparam int DONE_W       = 16;
  localparam int AGE_W        = 5;

  typedef logic [CNT_W-1:0]   pcnt_t;
  typedef logic [NUM_REQ-1:0] reqvec_t;
  typedef logic [AGE_W-1:0]   age_t;

  localparam pcnt_t CNT_MAX = '1;

  // Returns true when zero or one bit of v is set.
  function automatic logic at_most_one_hot(input reqvec_t v);
    return (v & (v - reqvec_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/ps_req_tracker_if.sv
// Client/selector-facing bundle of the request tracker.
// The master modport is the client/selector side; slave is the tracker.
interface ps_req_tracker_if;
  import ps_pkg::*;

  reqvec_t                   push;
  reqvec_t                   push_ok;
  reqvec_t                   req;
  logic                      en;
  reqvec_t                   gnt;
  reqvec_t                   starve;
  logic [NUM_REQ*CNT_W-1:0]  pend_cnt;
  logic [DONE_W-1:0]         done_cnt;
  logic                      gnt_err;

  modport master (
    output push, gnt,
    input  push_ok, req, en, starve, pend_cnt, done_cnt, gnt_err
  );

  modport slave (
    input  push, gnt,
    output push_ok, req, en, starve, pend_cnt, done_cnt, gnt_err
  );

endinterface

// File: rtl/ps_req_tracker_slot.sv
// One request line: saturating pending count plus a wait-age register
// that flags starvation after STARVE_LIMIT ungranted cycles.
module ps_req_slot
  import ps_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  push_i,
  input  logic  gnt_ok_i,
  input  logic  legal_i,
  output logic  req_o,
  output logic  push_ok_o,
  output logic  starve_o,
  output pcnt_t count_o
);

  pcnt_t count_q, count_d;
  age_t  age_q, age_d;
  logic  acc, ret;

  assign push_ok_o = (count_q != CNT_MAX);
  assign req_o     = (count_q != '0);
  assign starve_o  = (age_q == age_t'(STARVE_LIMIT));
  assign count_o   = count_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    acc     = push_i & push_ok_o;
    ret     = gnt_ok_i & legal_i;
    count_d = count_q;
    age_d   = age_q;
    if (acc && !ret)      count_d = count_q + pcnt_t'(1);
    else if (!acc && ret) count_d = count_q - pcnt_t'(1);
    // Without a grant a pending line is waiting, so the age keeps climbing.
    if (ret || count_q == '0)                    age_d = '0;
    else if (age_q != age_t'(STARVE_LIMIT))      age_d = age_q + age_t'(1);
  end

  // NOTE: registers use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      age_q   <= '0;
    end else begin
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: rtl/ps_req_tracker.sv
// Requester-side tracker for a ps8 selector: per-line pending counts,
// grant legality checking, retired-request counter and sticky error flag.
module ps_req_tracker
  import ps_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  ps_req_tracker_if.slave  bus
);

  reqvec_t                  req, push_ok, starve, gnt_ok;
  logic [NUM_REQ*CNT_W-1:0] pend;
  logic                     legal;
  logic [DONE_W-1:0]        done_q, done_d;
  logic                     err_q, err_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    ps_req_slot u_slot (
      .clock     (clock),
      .reset     (reset),
      .push_i    (bus.push[i]),
      .gnt_ok_i  (gnt_ok[i]),
      .legal_i   (legal),
      .req_o     (req[i]),
      .push_ok_o (push_ok[i]),
      .starve_o  (starve[i]),
      .count_o   (pend[i*CNT_W +: CNT_W])
    );
  end

  // An illegal grant retires nothing; every line treats it as no grant.
  always_comb begin
    legal  = at_most_one_hot(bus.gnt) && ((bus.gnt & ~req) == '0);
    gnt_ok = bus.gnt & {NUM_REQ{legal}};
    done_d = done_q;
    err_d  = err_q | ~legal;
    if (legal && (bus.gnt != '0)) done_d = done_q + DONE_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.req      = req;
  assign bus.en       = |req;
  assign bus.push_ok  = push_ok;
  assign bus.starve   = starve;
  assign bus.pend_cnt = pend;
  assign bus.done_cnt = done_q;
  assign bus.gnt_err  = err_q;

endmodule

// File: tb/tb_ps_req_tracker.sv
// Directed bench for ps_req_tracker: a behavioural model queues the expected
// outputs for each driven cycle, and they are popped and compared after the edge.
module tb_ps_req_tracker;
  import ps_pkg::*;

  typedef struct {
    logic [NUM_REQ*CNT_W-1:0] pend;
    reqvec_t                  req;
    logic                     en;
    reqvec_t                  push_ok;
    reqvec_t                  starve;
    logic [DONE_W-1:0]        done;
    logic                     err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  ps_req_tracker_if bus ();

  ps_req_tracker dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  int m_cnt [NUM_REQ];
  int m_age [NUM_REQ];
  int m_done;
  bit m_err;

  function automatic reqvec_t model_req();
    reqvec_t r = '0;
    for (int i = 0; i < NUM_REQ; i++) r[i] = (m_cnt[i] != 0);
    return r;
  endfunction

  // Bench-side ps8: highest-numbered request wins.
  function automatic reqvec_t ps8(input reqvec_t r);
    reqvec_t g = '0;
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) g = reqvec_t'(1) << i;
    return g;
  endfunction

  function automatic int popcount(input reqvec_t v);
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_update(input logic rst, input reqvec_t p, input reqvec_t g);
    bit      lgl;
    reqvec_t r;
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin m_cnt[i] = 0; m_age[i] = 0; end
      m_done = 0;
      m_err  = 0;
      return;
    end
    r   = model_req();
    lgl = (popcount(g) <= 1) && ((g & ~r) == '0);
    for (int i = 0; i < NUM_REQ; i++) begin
      bit acc, ret;
      acc = p[i] && (m_cnt[i] < 7);
      ret = lgl && g[i];
      if (ret || m_cnt[i] == 0) m_age[i] = 0;
      else if (m_age[i] < STARVE_LIMIT) m_age[i]++;
      m_cnt[i] = m_cnt[i] + int'(acc) - int'(ret);
    end
    if (lgl && g != '0) m_done = (m_done + 1) % 65536;
    if (!lgl) m_err = 1;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.pend    = '0;
    e.req     = '0;
    e.push_ok = '0;
    e.starve  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      e.pend[i*CNT_W +: CNT_W] = pcnt_t'(m_cnt[i]);
      e.req[i]     = (m_cnt[i] != 0);
      e.push_ok[i] = (m_cnt[i] != 7);
      e.starve[i]  = (m_age[i] == STARVE_LIMIT);
    end
    e.en   = (e.req != '0);
    e.done = DONE_W'(m_done);
    e.err  = m_err;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".pend_cnt"}, 32'(bus.pend_cnt), 32'(e.pend));
    chk({tag, ".req"},      32'(bus.req),      32'(e.req));
    chk({tag, ".en"},       32'(bus.en),       32'(e.en));
    chk({tag, ".push_ok"},  32'(bus.push_ok),  32'(e.push_ok));
    chk({tag, ".starve"},   32'(bus.starve),   32'(e.starve));
    chk({tag, ".done_cnt"}, 32'(bus.done_cnt), 32'(e.done));
    chk({tag, ".gnt_err"},  32'(bus.gnt_err),  32'(e.err));
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic rst, input reqvec_t p, input reqvec_t g);
    reset    = rst;
    bus.push = p;
    bus.gnt  = g;
    model_update(rst, p, g);
    exp_q.push_back(model_outputs());
    @(posedge clock);
    @(negedge clock);
    compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.push = '0;
    bus.gnt  = '0;
    @(negedge clock);

    // 1: reset wins over push/gnt, then idle.
    step("t1_reset", 1'b1, 8'hFF, 8'h01);
    for (int i = 0; i < 5; i++) step("t1_idle", 1'b0, '0, '0);

    // 2: two lines pending, selector in the loop.
    step("t2_push", 1'b0, 8'h81, '0);
    step("t2_gnt80", 1'b0, '0, ps8(model_req()));
    step("t2_gnt01", 1'b0, '0, ps8(model_req()));
    step("t2_idle", 1'b0, '0, ps8(model_req()));

    // 3: fill line 2 past max, then push+grant while full.
    for (int i = 0; i < 8; i++) step("t3_fill", 1'b0, 8'h04, '0);
    step("t3_full_push_gnt", 1'b0, 8'h04, 8'h04);

    // 4: starvation on line 0.
    step("t4_reset", 1'b1, '0, '0);
    step("t4_push", 1'b0, 8'h01, '0);
    for (int i = 0; i < 17; i++) step("t4_wait", 1'b0, '0, '0);
    step("t4_gnt", 1'b0, '0, 8'h01);
    step("t4_after", 1'b0, '0, '0);

    // 5: illegal grants, sticky error, pushes still accepted.
    step("t5_reset", 1'b1, '0, '0);
    step("t5_push", 1'b0, 8'h03, '0);
    step("t5_twohot", 1'b0, '0, 8'h03);
    step("t5_noreq", 1'b0, 8'h10, 8'h10);
    step("t5_hold", 1'b0, '0, '0);
    step("t5_legal_after", 1'b0, '0, 8'h02);
    step("t5_clear", 1'b1, '0, '0);

    // 6: simultaneous push+grant, then reset mid-burst.
    for (int i = 0; i < 3; i++) step("t6_fill", 1'b0, 8'h20, '0);
    step("t6_push_gnt", 1'b0, 8'h20, 8'h20);
    step("t6_burst", 1'b0, 8'hFF, 8'h20);
    step("t6_burst", 1'b0, 8'hFF, ps8(model_req()));
    step("t6_reset", 1'b1, 8'hFF, 8'h20);
    step("t6_idle", 1'b0, '0, '0);

    // Mixed traffic with legal selector grants plus occasional illegal ones.
    for (int i = 0; i < 30; i++) begin
      reqvec_t p, g;
      p = reqvec_t'($urandom_range(0, 255));
      g = ps8(model_req());
      if (i % 10 == 9) g = reqvec_t'($urandom_range(0, 255));
      step("mix", 1'b0, p, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
